painter_qsys_led_ctl: RTL and testbench
=======================================

# painter_qsys_led_ctl

Parametrised Avalon-MM LED output controller for the painter Qsys system. It is the successor to the fixed 10-bit LED PIO and generalises the output width. It adds atomic set/clear registers, per-channel hardware blink and a global PWM brightness stage. The Nios software drives it through a zero-wait-state slave; `out_port` connects directly to the board LEDs.

## Interface
- `WIDTH`, 10: number of LED channels, 1..32.
- `PERIOD_W`, 24: width of the blink half-period register and its counter.
- `DUTY_W`, 8: width of the PWM duty register and its counter, 1..16.
- `RESET_VALUE`, 0: reset value of the DATA register, `WIDTH` bits.
- `clk`, in, 1: sole clock; every register is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `address`, in, 3: register select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe. A write occurs when `chipselect && !write_n`.
- `writedata`, in, 32: write data. Bits above each register's width are ignored.
- `readdata`, out, 32: combinational read mux, zero-extended.
- `out_port`, out, `WIDTH`: registered LED drive.

## Operation
Register map:
- 0 DATA, R/W, `WIDTH` bits: LED enables. A write replaces all bits.
- 1 BLINK_MASK, R/W, `WIDTH` bits: a 1 makes that channel follow the blink phase.
- 2 BLINK_PERIOD, R/W, `PERIOD_W` bits: half-period in clocks. 0 disables blinking.
- 3 DUTY, R/W, `DUTY_W` bits: global brightness.
- 4 OUTSET, W/O: DATA <= DATA | wd. Reads return 0.
- 5 OUTCLEAR, W/O: DATA <= DATA & ~wd. Reads return 0.
- 6, 7: reserved. Reads return 0; writes are ignored.

Blink engine:
- BLINK_PERIOD == 0: `blink_cnt` holds 0 and `phase` holds 1.
- Otherwise `blink_cnt` counts 0..P-1. When it is at P-1 it wraps to 0 and `phase` toggles. Full blink period is 2P clocks.
- Any write to BLINK_PERIOD forces `blink_cnt` to 0 and `phase` to 1 on the same edge. This holds even if the written value equals the old one.

PWM engine:
- `pwm_cnt` is a free-running `DUTY_W`-bit counter that wraps from all-ones to 0.
- `pwm_on = (DUTY == all-ones) | (pwm_cnt < DUTY)`, unsigned compare.
- DUTY = 0 gives always off. DUTY = all-ones gives always on. Any other value D gives D on-cycles per 2^DUTY_W.

Output:
- Next `out_port[i] = DATA[i] & (BLINK_MASK[i] ? phase : 1) & pwm_on`.
- The expression is evaluated from current register and counter values and registered every clock.

Reset values:
- DATA = `RESET_VALUE`; BLINK_MASK = 0; BLINK_PERIOD = 0; DUTY = all-ones.
- `blink_cnt` = 0, `pwm_cnt` = 0, `phase` = 1.
- `out_port` = `RESET_VALUE`.
- `readdata` follows the reset register values.

## Timing
- Writes are sampled on the rising edge where `chipselect && !write_n`. The register holds the new value after that edge (edge k).
- `out_port` reflects the new value after edge k+1: one cycle of output latency.
- Reads are zero-latency: `readdata` is valid in the same cycle as `address`. The slave has no wait states and `chipselect` alone has no side effects.
- Only one write occurs per cycle, so DATA/OUTSET/OUTCLEAR never collide.
- The blink and PWM counters keep running during slave writes, except for the BLINK_PERIOD restart rule.
- Reset asserted mid-blink or mid-PWM clears all state asynchronously. Counting resumes from 0 on the first edge after deassertion.
- Shrinking BLINK_PERIOD below the current count is safe: the forced restart makes overrun impossible.

## Configuration
- `LED_PWM_EN` defined: DUTY register, `pwm_cnt` and the compare are built.
- `LED_PWM_EN` undefined: none of these exist and `pwm_on` is constant 1. Address 3 reads 0 and ignores writes. Every other behaviour is identical.

## Test plan
- Reset: hold `reset` high 3 clocks with `RESET_VALUE`=0x2A5 -> `out_port`=0x2A5; reads of addresses 0..5 return 0x2A5, 0, 0, 0xFF, 0, 0.
- Set/clear: write DATA=0x00F, OUTSET 0x300, OUTCLEAR 0x005 -> DATA reads 0x30A; `out_port`=0x30A one clock after the last write.
- Blink: DATA=0x3FF, BLINK_MASK=0x001, BLINK_PERIOD=3 -> bit 0 follows 1,1,1,0,0,0,... from the cycle after the write; bits 9..1 stay 1. Rewrite period 3 mid-low-phase -> bit 0 returns to 1 on the next output edge.
- PWM (`LED_PWM_EN` set): DUTY=64, `DUTY_W`=8, DATA=0x001 -> exactly 64 high cycles per 256 on bit 0. DUTY=0 -> never high; DUTY=255 -> always high.
- Async reset mid-operation: assert `reset` between edges while blinking -> `out_port` equals `RESET_VALUE` immediately (no clock edge needed); all registers reset.
- Build without `LED_PWM_EN`: write 0x10 to address 3 -> reads 0; `out_port` equals DATA with blink masking only.

Source files
------------

// File: rtl/painter_qsys_led_ctl.sv
// rtl/painter_qsys_led_ctl.sv - Avalon-MM LED controller with set/clear, blink and PWM
//
// Purpose: zero-wait-state Avalon-MM slave driving WIDTH board LEDs. DATA holds
// the LED enables (with atomic OUTSET/OUTCLEAR aliases), BLINK_MASK selects
// channels gated by a shared blink phase, and an optional global PWM stage
// scales brightness.
//
// Optional feature macro: LED_PWM_EN (DUTY register, PWM counter and compare).
// Without it the PWM gate is constant 1 and address 3 reads 0 / ignores writes.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-high reset
//   address    - register select (0 DATA, 1 BLINK_MASK, 2 BLINK_PERIOD,
//                3 DUTY, 4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data, upper bits ignored per register width
//   readdata   - combinational, zero-extended read mux
//   out_port   - registered LED drive
module painter_qsys_led_ctl #(
  parameter int               WIDTH       = 10,
  parameter int               PERIOD_W    = 24,
  parameter int               DUTY_W      = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_DUTY   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic                wr_en;
  logic [WIDTH-1:0]    wd_w;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                pwm_on;

  // Upper writedata bits are intentionally discarded.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr_en = chipselect && !write_n;
  assign wd_w  = writedata[WIDTH-1:0];

  // Register file next-state. OUTSET/OUTCLEAR are read-modify-write aliases
  // of DATA; only one write per cycle so they never collide with DATA.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        A_DATA:   data_d   = wd_w;
        A_MASK:   mask_d   = wd_w;
        A_PERIOD: period_d = writedata[PERIOD_W-1:0];
        A_OUTSET: data_d   = data_q | wd_w;
        A_OUTCLR: data_d   = data_q & ~wd_w;
        default:  ;
      endcase
    end
  end

  // Blink engine. Any period write restarts the phase, which also means a
  // shrunken period can never leave the counter beyond its new wrap point.
  always_comb begin
    blink_cnt_d = blink_cnt_q + PERIOD_W'(1);
    phase_d     = phase_q;
    if ((wr_en && address == A_PERIOD) || period_q == '0) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == period_q - PERIOD_W'(1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] pwm_cnt_q;

  always_comb begin
    duty_d = duty_q;
    if (wr_en && address == A_DUTY) begin
      duty_d = writedata[DUTY_W-1:0];
    end
  end

  // All-ones is special-cased so full duty is truly always on.
  assign pwm_on = (duty_q == '1) | (pwm_cnt_q < duty_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= '1;
      pwm_cnt_q <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  assign out_d = data_q & (~mask_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= RESET_VALUE;
      mask_q      <= '0;
      period_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      out_q       <= RESET_VALUE;
    end else begin
      data_q      <= data_d;
      mask_q      <= mask_d;
      period_q    <= period_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]    = data_q;
      A_MASK:   readdata[WIDTH-1:0]    = mask_q;
      A_PERIOD: readdata[PERIOD_W-1:0] = period_q;
`ifdef LED_PWM_EN
      A_DUTY:   readdata[DUTY_W-1:0]   = duty_q;
`endif
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_painter_qsys_led_ctl.sv
// tb/tb_painter_qsys_led_ctl.sv - directed self-checking bench for painter_qsys_led_ctl
module tb_painter_qsys_led_ctl;

  localparam logic [9:0] RV = 10'h2A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int n_checks = 0;
  int n_errors = 0;

  painter_qsys_led_ctl #(
    .WIDTH       (10),
    .PERIOD_W    (24),
    .DUTY_W      (8),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [9:0] exp);
    check(tag, {22'd0, out_port}, {22'd0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("rst_out", RV);
    chk_rd("rst_data", 3'd0, 32'h2A5);
    chk_rd("rst_mask", 3'd1, 32'h0);
    chk_rd("rst_period", 3'd2, 32'h0);
`ifdef LED_PWM_EN
    chk_rd("rst_duty", 3'd3, 32'hFF);
`else
    chk_rd("rst_duty", 3'd3, 32'h0);
`endif
    chk_rd("rst_outset", 3'd4, 32'h0);
    chk_rd("rst_outclr", 3'd5, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_out("post_rst_out", RV);

    // Set/clear
    wr(3'd0, 32'h00F);
    wr(3'd4, 32'h300);
    wr(3'd5, 32'h005);
    chk_out("setclr_latency", 10'h30F);
    chk_rd("setclr_data", 3'd0, 32'h30A);
    @(negedge clk);
    chk_out("setclr_out", 10'h30A);

    // Reserved addresses
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    chk_rd("rsv_data", 3'd0, 32'h30A);
    chk_rd("rsv_rd6", 3'd6, 32'h0);
    chk_rd("rsv_rd7", 3'd7, 32'h0);

    // Blink: period 3 -> 1,1,1,0,0,0 on bit 0
    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h001);
    wr(3'd2, 32'h3);
    chk_rd("blink_period", 3'd2, 32'h3);
    chk_rd("blink_mask", 3'd1, 32'h1);
    chk_out("blink_k", 10'h3FF);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk_out($sformatf("blink_%0d", i), ((i % 6) < 3) ? 10'h3FF : 10'h3FE);
    end
    // Rewrite same period while the low phase is active.
    wr(3'd2, 32'h3);
    chk_out("restart_low", 10'h3FE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out($sformatf("restart_%0d", i), (i < 3) ? 10'h3FF : 10'h3FE);
    end

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst_out", RV);
    chk_rd("async_rst_data", 3'd0, 32'h2A5);
    chk_rd("async_rst_mask", 3'd1, 32'h0);
    chk_rd("async_rst_period", 3'd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_out("after_async_rst", RV);
    end

`ifdef LED_PWM_EN
    begin
      int cnt;
      wr(3'd0, 32'h001);
      wr(3'd3, 32'd64);
      chk_rd("pwm_duty_rd", 3'd3, 32'd64);
      @(negedge clk);
      cnt = 0;
      repeat (256) begin
        @(negedge clk);
        if (out_port[0]) cnt++;
      end
      check("pwm_64", cnt, 64);
      wr(3'd3, 32'd0);
      @(negedge clk);
      cnt = 0;
      repeat (256) begin
        @(negedge clk);
        if (out_port[0]) cnt++;
      end
      check("pwm_0", cnt, 0);
      wr(3'd3, 32'd255);
      @(negedge clk);
      cnt = 0;
      repeat (256) begin
        @(negedge clk);
        if (out_port[0]) cnt++;
      end
      check("pwm_255", cnt, 256);
    end
`else
    wr(3'd0, 32'h155);
    wr(3'd3, 32'h10);
    chk_rd("nopwm_duty_rd", 3'd3, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk_out("nopwm_out", 10'h155);
    end
    wr(3'd1, 32'h100);
    wr(3'd2, 32'h2);
    chk_out("nopwm_blink_k", 10'h155);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_out($sformatf("nopwm_blink_%0d", i), ((i % 4) < 2) ? 10'h155 : 10'h055);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
